// File: rtl/output_buffer_pkg.sv
// Shared constants and pointer helpers for the output_buffer circular store.
package output_buffer_pkg;
  localparam int OB_DATA_W = 8;
  localparam int OB_SLOTS  = 5;

  // Pointer width; a 1-bit pointer still works when the depth would give 0 bits.
  function automatic int ptr_w(input int slots);
    return (slots > 2) ? $clog2(slots) : 1;
  endfunction

  // Advances a pointer and wraps it at slots-1, so depths that are not a power of 2 work.
  function automatic int ptr_inc(input int p, input int slots);
    return (p == slots - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/output_buffer_mem.sv
// Storage array for output_buffer: one synchronous write port and one registered read port.
// Only the read register is reset. The storage contents keep their values through reset.
module output_buffer_mem
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = OB_DATA_W,
  parameter int SLOTS  = OB_SLOTS,
  parameter int PW     = ptr_w(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [SLOTS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/output_buffer.sv
// Output buffer at a router port: a FIFO store with a write acknowledge and a registered read port.
// Optional macro OUTPUT_BUFFER_OVERFLOW_EN adds a sticky overflow output.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DATA_W = OB_DATA_W,
  parameter int SLOTS  = OB_SLOTS,
  localparam int CW    = $clog2(SLOTS + 1),
  localparam int PW    = ptr_w(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              data_stored,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
`ifdef OUTPUT_BUFFER_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_fire, rd_fire;

  assign full    = (count == CW'(SLOTS));
  assign empty   = (count == '0);
  assign rd_fire = rd_en && !empty;
  // A write to a full buffer is accepted only when a read frees a slot on the same edge.
  assign wr_fire = en && (!full || rd_fire);

  output_buffer_mem #(.DATA_W(DATA_W), .SLOTS(SLOTS), .PW(PW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire && !rst),
    .waddr (wr_ptr),
    .wdata (data),
    .re    (rd_fire && !rst),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_stored <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      data_stored <= wr_fire;
      rd_valid    <= rd_fire;
      if (wr_fire) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), SLOTS));
      if (rd_fire) rd_ptr <= PW'(ptr_inc(int'(rd_ptr), SLOTS));
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef OUTPUT_BUFFER_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (en && full && !rd_fire)  overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: fill, drain, overflow drop, write while full with a read, reset priority, and read while empty.
module tb_output_buffer;
  localparam int DATA_W = 8;
  localparam int SLOTS  = 5;
  localparam int CW     = $clog2(SLOTS + 1);

  logic              clk = 1'b0;
  logic              rst, en, rd_en;
  logic [DATA_W-1:0] data;
  logic              data_stored, rd_valid, full, empty;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;
`ifdef OUTPUT_BUFFER_OVERFLOW_EN
  logic              overflow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_buffer #(.DATA_W(DATA_W), .SLOTS(SLOTS)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data        (data),
    .data_stored (data_stored),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count)
`ifdef OUTPUT_BUFFER_OVERFLOW_EN
    ,
    .overflow    (overflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 1; i <= SLOTS; i++) begin
      en = 1'b1; data = DATA_W'(i);
      tick();
      chk("fill_stored", 32'(data_stored), 1);
      chk("fill_count", 32'(count), i);
    end
    en = 1'b0;
    chk("fill_full", 32'(full), 1);
  endtask

  task automatic drain(input int first);
    for (int i = 0; i < SLOTS; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), first + i);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_valid_off", 32'(rd_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd_en = 1'b0; data = '0;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_stored", 32'(data_stored), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    rst = 1'b0;

    // 1: fill with 0x01..0x05, then confirm the acknowledge drops
    fill();
    tick();
    chk("t1_stored_off", 32'(data_stored), 0);
    chk("t1_count", 32'(count), 5);

    // 2: drain in order
    drain(1);
    chk("t2_rdata_hold", 32'(rd_data), 5);

    // 3: write while full without a read is dropped
    fill();
    en = 1'b1; data = 8'hAA;
    tick();
    en = 1'b0;
    chk("t3_stored", 32'(data_stored), 0);
    chk("t3_count", 32'(count), 5);
`ifdef OUTPUT_BUFFER_OVERFLOW_EN
    chk("t3_overflow", 32'(overflow), 1);
`endif
    drain(1);

    // 4: write while full together with a read
    fill();
    en = 1'b1; data = 8'h06; rd_en = 1'b1;
    tick();
    en = 1'b0; rd_en = 1'b0;
    chk("t4_rdata", 32'(rd_data), 1);
    chk("t4_valid", 32'(rd_valid), 1);
    chk("t4_stored", 32'(data_stored), 1);
    chk("t4_count", 32'(count), 5);
    drain(2);

    // 5: reset has priority over a write and a read in the same cycle
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; data = DATA_W'(8'h10 + i);
      tick();
    end
    chk("t5_count_pre", 32'(count), 3);
    rst = 1'b1; en = 1'b1; rd_en = 1'b1; data = 8'h77;
    tick();
    rst = 1'b0; en = 1'b0; rd_en = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_stored", 32'(data_stored), 0);
    chk("t5_valid", 32'(rd_valid), 0);
`ifdef OUTPUT_BUFFER_OVERFLOW_EN
    chk("t5_overflow", 32'(overflow), 0);
`endif

    // 6: read while empty is ignored, and a new write is not bypassed to the read port
    rd_en = 1'b1;
    tick();
    chk("t6_empty_valid", 32'(rd_valid), 0);
    chk("t6_empty_count", 32'(count), 0);
    en = 1'b1; data = 8'h33;
    tick();
    en = 1'b0;
    chk("t6_nobypass_valid", 32'(rd_valid), 0);
    chk("t6_wr_stored", 32'(data_stored), 1);
    tick();
    rd_en = 1'b0;
    chk("t6_rd_valid", 32'(rd_valid), 1);
    chk("t6_rd_data", 32'(rd_data), 8'h33);
    chk("t6_empty_after", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
